ocra1_rx: RTL and testbench
===========================

# ocra1_rx

Synthesisable receiver for the OCRA1 four-channel DAC serial link. It sits on the far end of the `oc1_*` pins that `ocra1_iface` drives. It decodes the 24-bit AD5781-style frames on the x/y/z/z2 data lines and keeps per-channel input, DAC and control registers. Its outputs are `vout*_o` and `ctrl_o`, used for on-chip loopback checking and as the gradient monitor readback.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth on every `oc1_*` input; legal range 2–3.

Ports:
- `clk`  in  1: system clock, 125 MHz; all logic in this domain.
- `rst`  in  1: synchronous, active-high reset.
- `oc1_clk_i`  in  1: serial clock; asynchronous to `clk`.
- `oc1_syncn_i`  in  1: frame strobe; active low.
- `oc1_ldacn_i`  in  1: load-DAC strobe; active low.
- `oc1_sdox_i`, `oc1_sdoy_i`, `oc1_sdoz_i`, `oc1_sdoz2_i`  in  1 each: serial data, MSB first.
- `voutx_o`, `vouty_o`, `voutz_o`, `voutz2_o`  out  18 each: DAC register per channel.
- `ctrl_o`  out  80: control register per channel, 20 bits each; order {z2,z,y,x}.
- `rx_word_o`  out  96: last raw frames, 24 bits each; order {z2,z,y,x}.
- `rx_valid_o`  out  1: one-cycle pulse when a complete frame is accepted.
- `frame_err_o`  out  1: one-cycle pulse when a frame is rejected.

## Operation
- Each `oc1_*` input passes through a `SYNC_STAGES` flop chain. Edges are detected on the synchronised copies.
- Data is sampled on each detected falling edge of `oc1_clk_i`, while syncn is low. The four channels shift in parallel through 24-bit shift registers.
- FSM states:
  - IDLE: syncn high. A syncn falling edge clears the bit counter and moves to SHIFT.
  - SHIFT: counts sclk falls. The 25th fall moves to ERR. A syncn rise with count == 24 moves to COMMIT. A syncn rise with count ≠ 24 pulses `frame_err_o` and returns to IDLE.
  - ERR: waits for syncn rise, pulses `frame_err_o`, returns to IDLE.
  - COMMIT: lasts one cycle, pulses `rx_valid_o`, loads `rx_word_o`, returns to IDLE.
- Frame decode, per channel:
  - Bit 23 is R/W#; bits 22:20 are the address; bits 19:0 are the data.
  - Write, address 1: input register ← data[19:2].
  - Write, address 2: that channel's `ctrl_o` slice ← data[19:0].
  - Read frames and any other address: no register update, but `rx_valid_o` and `rx_word_o` still update.
- DAC update:
  - A detected ldacn falling edge copies all four input registers into `vout*_o`.
  - If synchronised ldacn is already low during COMMIT, the newly written values go straight through to `vout*_o` in that same cycle.
- Arithmetic: DAC codes are raw 18-bit values with no sign handling. An input of −1 appears as 0x3FFFF.

## Timing
- Reset: all outputs and registers are 0; FSM goes to IDLE; synchroniser flops are set to 1 (idle-high lines).
- Minimum `oc1_clk_i` half-period is `SYNC_STAGES`+1 `clk` cycles. `ocra1_iface` with `spi_clk_div_i` ≥ 4 satisfies this.
- Latency from the pin-level syncn rising edge to `rx_valid_o` is `SYNC_STAGES`+2 cycles. Input registers and `ctrl_o` update in the same cycle as `rx_valid_o`.
- Latency from the pin-level ldacn falling edge to `vout*_o` updating is `SYNC_STAGES`+1 cycles.
- If an ldacn fall and a COMMIT occur in the same cycle, the DAC registers load the newly committed values.
- A syncn fall seen in any state, including ERR, aborts the current frame without an error pulse and restarts SHIFT.
- Reset asserted mid-frame discards the partial frame; no pulse is emitted.

## Structure
- Package `ocra1_pkg`:
  - `FRAME_BITS` = 24.
  - `ADDR_DAC` = 1, `ADDR_CTRL` = 2.
  - FSM state enum.
  - Field-slice localparams for R/W, address and data.
- Sub-module `ocra1_rx_sync`: parameterised synchroniser plus rise/fall detector. Instantiated once per input line (7 instances).

## Test plan
All scenarios drive the receiver from `ocra1_iface`, `spi_clk_div_i`=32.
- Reset: hold `rst` 3 cycles → every output is 0 and no pulses appear.
- Init: send 0x200002 on all channels → one `rx_valid_o` pulse; each `ctrl_o` slice = 0x00002; `vout*_o` stay 0.
- Voltage write: sendV(1,2,3,4), then an ldacn pulse → `voutx_o`=1, `vouty_o`=2, `voutz_o`=3, `voutz2_o`=4, exactly `SYNC_STAGES`+1 cycles after the ldacn fall. sendV(-1,-2,-3,-4) → 0x3FFFF, 0x3FFFE, 0x3FFFD, 0x3FFFC.
- Bad frames: a 20-bit frame, then a 25-bit frame (bench-driven pins) → one `frame_err_o` pulse each; no register changes; `rx_valid_o` stays low.
- ldacn held low: frame 0x100010 on x → `voutx_o`=4 in the `rx_valid_o` cycle.
- Reset mid-frame: assert `rst` after 10 bits, then send a full sendV(5,6,7,8) → clean reception, no `frame_err_o`.

Source files
------------

// File: rtl/ocra1_pkg.sv
// rtl/ocra1_pkg.sv - shared constants, frame field slices and FSM states for the OCRA1 receiver
package ocra1_pkg;
    localparam int FRAME_BITS = 24;

    localparam logic [2:0] ADDR_DAC  = 3'd1;
    localparam logic [2:0] ADDR_CTRL = 3'd2;

    localparam int RW_BIT  = 23;
    localparam int ADDR_HI = 22;
    localparam int ADDR_LO = 20;
    localparam int DATA_HI = 19;
    localparam int DATA_LO = 0;
    localparam int DAC_LO  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ERR,
        ST_COMMIT
    } rx_state_t;
endpackage

// File: rtl/ocra1_rx_if.sv
// rtl/ocra1_rx_if.sv - OCRA1 serial pin bundle with driver and receiver modports
interface ocra1_rx_if;
    logic oc1_clk_i;
    logic oc1_syncn_i;
    logic oc1_ldacn_i;
    logic oc1_sdox_i;
    logic oc1_sdoy_i;
    logic oc1_sdoz_i;
    logic oc1_sdoz2_i;

    modport master (
        output oc1_clk_i, oc1_syncn_i, oc1_ldacn_i,
        output oc1_sdox_i, oc1_sdoy_i, oc1_sdoz_i, oc1_sdoz2_i
    );

    modport slave (
        input oc1_clk_i, oc1_syncn_i, oc1_ldacn_i,
        input oc1_sdox_i, oc1_sdoy_i, oc1_sdoz_i, oc1_sdoz2_i
    );
endinterface

// File: rtl/ocra1_rx_sync.sv
// rtl/ocra1_rx_sync.sv - input synchroniser with rise/fall detection on the synchronised copy
module ocra1_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '1;
            prev  <= 1'b1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/ocra1_rx.sv
// rtl/ocra1_rx.sv - OCRA1 four-channel DAC serial link receiver
module ocra1_rx
    import ocra1_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    ocra1_rx_if.slave         oc1,
    output logic [17:0]       voutx_o,
    output logic [17:0]       vouty_o,
    output logic [17:0]       voutz_o,
    output logic [17:0]       voutz2_o,
    output logic [79:0]       ctrl_o,
    output logic [95:0]       rx_word_o,
    output logic              rx_valid_o,
    output logic              frame_err_o
);
    // Line index: 0 sclk, 1 syncn, 2 ldacn, 3..6 sdo x/y/z/z2.
    logic [6:0] pins, q, rise, fall;

    assign pins = {oc1.oc1_sdoz2_i, oc1.oc1_sdoz_i, oc1.oc1_sdoy_i, oc1.oc1_sdox_i,
                   oc1.oc1_ldacn_i, oc1.oc1_syncn_i, oc1.oc1_clk_i};

    for (genvar i = 0; i < 7; i++) begin : g_sync
        ocra1_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .rst  (rst),
            .d    (pins[i]),
            .q    (q[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    logic unused_edges;
    assign unused_edges = ^{rise[6:3], rise[2], rise[0], fall[6:3], q[0]};

    logic              sclk_fall, syncn_q, syncn_rise, syncn_fall, ldacn_q, ldacn_fall;
    logic [3:0]        sdo_q;

    assign sclk_fall  = fall[0];
    assign syncn_q    = q[1];
    assign syncn_rise = rise[1];
    assign syncn_fall = fall[1];
    assign ldacn_q    = q[2];
    assign ldacn_fall = fall[2];
    assign sdo_q      = q[6:3];

    rx_state_t         state;
    logic [4:0]        bit_cnt;
    logic [3:0][23:0]  shreg;
    logic [3:0][17:0]  in_reg, in_next, vout;
    logic [3:0][19:0]  ctrl_r, ctrl_next;

    // Register writes decoded from the shift registers while in COMMIT.
    always_comb begin
        in_next   = in_reg;
        ctrl_next = ctrl_r;
        if (state == ST_COMMIT) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (!shreg[ch][RW_BIT]) begin
                    if (shreg[ch][ADDR_HI:ADDR_LO] == ADDR_DAC)
                        in_next[ch] = shreg[ch][DATA_HI:DAC_LO];
                    else if (shreg[ch][ADDR_HI:ADDR_LO] == ADDR_CTRL)
                        ctrl_next[ch] = shreg[ch][DATA_HI:DATA_LO];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            in_reg      <= '0;
            vout        <= '0;
            ctrl_r      <= '0;
            rx_word_o   <= '0;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            in_reg      <= in_next;
            ctrl_r      <= ctrl_next;
            // in_next covers both an ldac edge coinciding with COMMIT and ldac held low.
            if (ldacn_fall || (state == ST_COMMIT && !ldacn_q))
                vout <= in_next;
            if (state == ST_COMMIT) begin
                rx_valid_o <= 1'b1;
                rx_word_o  <= shreg;
            end
            if (syncn_fall) begin
                state   <= ST_SHIFT;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (syncn_rise) begin
                            if (bit_cnt == 5'(FRAME_BITS)) begin
                                state <= ST_COMMIT;
                            end else begin
                                frame_err_o <= 1'b1;
                                state       <= ST_IDLE;
                            end
                        end else if (sclk_fall && !syncn_q) begin
                            if (bit_cnt == 5'(FRAME_BITS)) begin
                                state <= ST_ERR;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                for (int ch = 0; ch < 4; ch++)
                                    shreg[ch] <= {shreg[ch][22:0], sdo_q[ch]};
                            end
                        end
                    end
                    ST_ERR: begin
                        if (syncn_rise) begin
                            frame_err_o <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                    ST_COMMIT: state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    assign voutx_o  = vout[0];
    assign vouty_o  = vout[1];
    assign voutz_o  = vout[2];
    assign voutz2_o = vout[3];
    assign ctrl_o   = ctrl_r;
endmodule

// File: tb/tb_ocra1_rx.sv
// tb/tb_ocra1_rx.sv - self-checking bench for ocra1_rx against a cycle-scheduled behavioural model
module tb_ocra1_rx;
    localparam int S    = 2;
    localparam int HALF = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    ocra1_rx_if bus ();

    logic [17:0] voutx_o, vouty_o, voutz_o, voutz2_o;
    logic [79:0] ctrl_o;
    logic [95:0] rx_word_o;
    logic        rx_valid_o, frame_err_o;

    ocra1_rx #(.SYNC_STAGES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .oc1         (bus.slave),
        .voutx_o     (voutx_o),
        .vouty_o     (vouty_o),
        .voutz_o     (voutz_o),
        .voutz2_o    (voutz2_o),
        .ctrl_o      (ctrl_o),
        .rx_word_o   (rx_word_o),
        .rx_valid_o  (rx_valid_o),
        .frame_err_o (frame_err_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model events: 0 commit, 1 frame error, 2 ldac fall, 3 ldac rise.
    typedef struct {
        int          at;
        int          kind;
        logic [95:0] w;
    } ev_t;
    ev_t ev_q[$];

    logic [3:0][17:0] exp_in, exp_vout;
    logic [3:0][19:0] exp_ctrl;
    logic [95:0]      exp_word;
    logic             exp_valid, exp_err, ldac_low;

    task automatic model_reset();
        exp_in = '0; exp_vout = '0; exp_ctrl = '0; exp_word = '0;
        exp_valid = 1'b0; exp_err = 1'b0; ldac_low = 1'b0;
        ev_q.delete();
    endtask

    task automatic apply(ev_t e);
        logic [23:0] wc;
        case (e.kind)
            0: begin
                exp_word  = e.w;
                exp_valid = 1'b1;
                for (int ch = 0; ch < 4; ch++) begin
                    wc = e.w[ch*24 +: 24];
                    if (wc[23] == 1'b0 && wc[22:20] == 3'd1) exp_in[ch] = wc[19:2];
                    if (wc[23] == 1'b0 && wc[22:20] == 3'd2) exp_ctrl[ch] = wc[19:0];
                end
                if (ldac_low) exp_vout = exp_in;
            end
            1: exp_err = 1'b1;
            2: begin ldac_low = 1'b1; exp_vout = exp_in; end
            default: ldac_low = 1'b0;
        endcase
    endtask

    always @(negedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            for (int k = 0; k < 4; k++)
                foreach (ev_q[i])
                    if (ev_q[i].at == cyc && ev_q[i].kind == k) apply(ev_q[i]);
            for (int i = ev_q.size() - 1; i >= 0; i--)
                if (ev_q[i].at <= cyc) ev_q.delete(i);
        end
        chk("rx_valid", 96'(rx_valid_o), 96'(exp_valid));
        chk("frame_err", 96'(frame_err_o), 96'(exp_err));
        chk("voutx", 96'(voutx_o), 96'(exp_vout[0]));
        chk("vouty", 96'(vouty_o), 96'(exp_vout[1]));
        chk("voutz", 96'(voutz_o), 96'(exp_vout[2]));
        chk("voutz2", 96'(voutz2_o), 96'(exp_vout[3]));
        chk("ctrl", 96'(ctrl_o), 96'(exp_ctrl));
        chk("rx_word", rx_word_o, exp_word);
    end

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(int at, int kind, logic [95:0] w);
        ev_t e;
        e.at = at; e.kind = kind; e.w = w;
        ev_q.push_back(e);
    endtask

    task automatic drive_bits(logic [95:0] w, int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.oc1_sdox_i  = (i < 24) ? w[23 - i]      : 1'b0;
            bus.oc1_sdoy_i  = (i < 24) ? w[24 + 23 - i] : 1'b0;
            bus.oc1_sdoz_i  = (i < 24) ? w[48 + 23 - i] : 1'b0;
            bus.oc1_sdoz2_i = (i < 24) ? w[72 + 23 - i] : 1'b0;
            wait_cyc(HALF);
            bus.oc1_clk_i = 1'b0;
            wait_cyc(HALF);
            bus.oc1_clk_i = 1'b1;
        end
    endtask

    // Returns right after the syncn rise; the result lands S+1 or S+2 cycles later.
    task automatic send_frame(logic [95:0] w, int nbits);
        bus.oc1_syncn_i = 1'b0;
        wait_cyc(HALF);
        drive_bits(w, nbits);
        wait_cyc(HALF);
        bus.oc1_syncn_i = 1'b1;
        if (nbits == 24) push(cyc + S + 2, 0, w);
        else             push(cyc + S + 1, 1, w);
    endtask

    function automatic logic [23:0] vword(int v);
        logic [17:0] code;
        code = 18'(v);
        return {4'h1, code, 2'b00};
    endfunction

    task automatic send_v(int a, int b, int c, int d);
        send_frame({vword(d), vword(c), vword(b), vword(a)}, 24);
        wait_cyc(2 * HALF);
    endtask

    task automatic ldac_pulse();
        bus.oc1_ldacn_i = 1'b0;
        push(cyc + S + 1, 2, '0);
        wait_cyc(HALF);
        bus.oc1_ldacn_i = 1'b1;
        push(cyc + S + 1, 3, '0);
        wait_cyc(HALF);
    endtask

    task automatic wait_valid(string name);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (rx_valid_o) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: got no rx_valid expected pulse within 200 cycles", name);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] w;
        int          start;
        bus.oc1_clk_i = 1'b1; bus.oc1_syncn_i = 1'b1; bus.oc1_ldacn_i = 1'b1;
        bus.oc1_sdox_i = 1'b0; bus.oc1_sdoy_i = 1'b0; bus.oc1_sdoz_i = 1'b0; bus.oc1_sdoz2_i = 1'b0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(5);

        send_frame({4{24'h200002}}, 24);
        wait_cyc(2 * HALF);
        chk("init_ctrl", 96'(ctrl_o), 96'({4{20'h00002}}));
        chk("init_voutx", 96'(voutx_o), 96'd0);

        send_v(1, 2, 3, 4);
        bus.oc1_ldacn_i = 1'b0;
        start = cyc;
        push(start + S + 1, 2, '0);
        repeat (S) @(negedge clk);
        chk("ldac_lat_before", 96'(voutx_o), 96'd0);
        @(negedge clk);
        chk("ldac_lat_at", 96'(voutx_o), 96'd1);
        #1;
        wait_cyc(HALF);
        bus.oc1_ldacn_i = 1'b1;
        push(cyc + S + 1, 3, '0);
        wait_cyc(HALF);
        chk("v1_y", 96'(vouty_o), 96'd2);
        chk("v1_z", 96'(voutz_o), 96'd3);
        chk("v1_z2", 96'(voutz2_o), 96'd4);

        send_v(-1, -2, -3, -4);
        ldac_pulse();
        chk("neg_x", 96'(voutx_o), 96'h3FFFF);
        chk("neg_y", 96'(vouty_o), 96'h3FFFE);
        chk("neg_z", 96'(voutz_o), 96'h3FFFD);
        chk("neg_z2", 96'(voutz2_o), 96'h3FFFC);

        send_frame({4{24'h10ABCD}}, 20);
        wait_cyc(2 * HALF);
        send_frame({4{24'h100004}}, 25);
        wait_cyc(2 * HALF);
        ldac_pulse();
        chk("bad_keep_x", 96'(voutx_o), 96'h3FFFF);
        chk("bad_keep_ctrl", 96'(ctrl_o), 96'({4{20'h00002}}));

        bus.oc1_ldacn_i = 1'b0;
        push(cyc + S + 1, 2, '0);
        wait_cyc(S + 4);
        send_frame({24'h800000, 24'h800000, 24'h800000, 24'h100010}, 24);
        wait_valid("held_valid");
        chk("held_voutx", 96'(voutx_o), 96'd4);
        chk("held_vouty", 96'(vouty_o), 96'h3FFFE);
        #1;
        wait_cyc(2 * HALF);
        bus.oc1_ldacn_i = 1'b1;
        push(cyc + S + 1, 3, '0);
        wait_cyc(HALF);

        // ldac fall lands in the COMMIT cycle: the new code must be loaded.
        send_frame({vword(12), vword(11), vword(10), vword(9)}, 24);
        wait_cyc(1);
        bus.oc1_ldacn_i = 1'b0;
        push(cyc + S + 1, 2, '0);
        wait_cyc(HALF);
        chk("same_cycle_x", 96'(voutx_o), 96'd9);
        bus.oc1_ldacn_i = 1'b1;
        push(cyc + S + 1, 3, '0);
        wait_cyc(HALF);

        bus.oc1_syncn_i = 1'b0;
        wait_cyc(HALF);
        drive_bits({4{vword(99)}}, 10);
        rst = 1'b1;
        bus.oc1_syncn_i = 1'b1;
        bus.oc1_clk_i = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(5);
        send_v(5, 6, 7, 8);
        ldac_pulse();
        chk("rst_x", 96'(voutx_o), 96'd5);
        chk("rst_y", 96'(vouty_o), 96'd6);
        chk("rst_z", 96'(voutz_o), 96'd7);
        chk("rst_z2", 96'(voutz2_o), 96'd8);

        for (int n = 0; n < 20; n++) begin
            int nb;
            int r;
            for (int ch = 0; ch < 4; ch++)
                w[ch*24 +: 24] = {($urandom_range(0, 3) == 0), 3'($urandom_range(0, 3)), 20'($urandom)};
            r  = $urandom_range(0, 9);
            nb = (r == 0) ? 20 : (r == 1) ? 25 : 24;
            send_frame(w, nb);
            wait_cyc(2 * HALF);
            if ($urandom_range(0, 1) == 1) ldac_pulse();
        end
        wait_cyc(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
